// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: bars, grid, gradient and scrolling bars on a
// two-stage pipeline, with HS/VS delayed to stay aligned with RGB.
module vga_pattern_gen #(
  parameter int HDISP       = 640,
  parameter int VDISP       = 480,
  parameter int HPERIOD     = 800,
  parameter int VPERIOD     = 525,
  parameter int BARW        = 80,
  parameter int SCROLL_STEP = 2
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic [9:0] HCNT,
  input  logic [9:0] VCNT,
  input  logic       HS_IN,
  input  logic       VS_IN,
  input  logic [1:0] MODE,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [7:0] FRAME
);

  localparam logic [9:0]  H_LAST = 10'(HPERIOD - 1);
  localparam logic [9:0]  V_LAST = 10'(VPERIOD - 1);
  localparam logic [9:0]  H_DISP = 10'(HDISP);
  localparam logic [9:0]  V_DISP = 10'(VDISP);
  localparam logic [9:0]  H_EDGE = 10'(HDISP - 1);
  localparam logic [9:0]  V_EDGE = 10'(VDISP - 1);
  localparam logic [10:0] X_WRAP = 11'(HDISP);

  logic       fe;
  logic [1:0] mode_q;
  logic [7:0] frame_q;

  // Stage-1 registers
  logic       active_q, grid_q, hs1_q, vs1_q;
  logic [1:0] mode1_q;
  logic [2:0] bi_q, bis_q;
  logic [3:0] hgrad_q, vgrad_q, fgrad_q;

  // Stage-2 registers
  logic [3:0] r_q, g_q, b_q;
  logic [3:0] r_d, g_d, b_d;
  logic       hs2_q, vs2_q;

  logic [10:0] x_ext, xsum, xs;
  logic [6:0]  ge_x, ge_xs;
  logic [2:0]  bi_d, bis_d;
  logic        active_d, grid_d;

  assign fe = (HCNT == H_LAST) && (VCNT == V_LAST);

  // Scroll offset is at most 2*255, so one conditional subtract wraps it.
  assign x_ext = {1'b0, HCNT};
  assign xsum  = x_ext + 11'(SCROLL_STEP * int'(frame_q));
  assign xs    = (xsum >= X_WRAP) ? (xsum - X_WRAP) : xsum;

  // Thermometer compare chain against bar boundaries; bar index is its popcount.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_bar_cmp
      assign ge_x[gi]  = (x_ext >= 11'((gi + 1) * BARW));
      assign ge_xs[gi] = (xs    >= 11'((gi + 1) * BARW));
    end
  endgenerate

  assign bi_d     = 3'($countones(ge_x));
  assign bis_d    = 3'($countones(ge_xs));
  assign active_d = (HCNT < H_DISP) && (VCNT < V_DISP);
  assign grid_d   = (HCNT[4:0] == 5'd0) || (VCNT[4:0] == 5'd0) ||
                    (HCNT == H_EDGE) || (VCNT == V_EDGE);

  always_comb begin
    r_d = 4'h0;
    g_d = 4'h0;
    b_d = 4'h0;
    if (active_q) begin
      unique case (mode1_q)
        2'd0: begin
          r_d = {4{~bi_q[2]}};
          g_d = {4{~bi_q[1]}};
          b_d = {4{~bi_q[0]}};
        end
        2'd1: begin
          r_d = {4{grid_q}};
          g_d = {4{grid_q}};
          b_d = {4{grid_q}};
        end
        2'd2: begin
          r_d = hgrad_q;
          g_d = vgrad_q;
          b_d = fgrad_q;
        end
        default: begin
          r_d = {4{~bis_q[2]}};
          g_d = {4{~bis_q[1]}};
          b_d = {4{~bis_q[0]}};
        end
      endcase
    end
  end

  always_ff @(posedge PCK) begin
    if (RST) begin
      mode_q   <= 2'd0;
      frame_q  <= 8'd0;
      active_q <= 1'b0;
      grid_q   <= 1'b0;
      mode1_q  <= 2'd0;
      bi_q     <= 3'd0;
      bis_q    <= 3'd0;
      hgrad_q  <= 4'h0;
      vgrad_q  <= 4'h0;
      fgrad_q  <= 4'h0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      r_q      <= 4'h0;
      g_q      <= 4'h0;
      b_q      <= 4'h0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
    end else begin
      if (fe) begin
        mode_q  <= MODE;
        frame_q <= frame_q + 8'd1;
      end
      active_q <= active_d;
      grid_q   <= grid_d;
      mode1_q  <= mode_q;
      bi_q     <= bi_d;
      bis_q    <= bis_d;
      hgrad_q  <= HCNT[7:4];
      vgrad_q  <= VCNT[7:4];
      fgrad_q  <= frame_q[7:4];
      hs1_q    <= HS_IN;
      vs1_q    <= VS_IN;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
      hs2_q    <= hs1_q;
      vs2_q    <= vs1_q;
    end
  end

  assign VGA_R  = r_q;
  assign VGA_G  = g_q;
  assign VGA_B  = b_q;
  assign VGA_HS = hs2_q;
  assign VGA_VS = vs2_q;
  assign FRAME  = frame_q;

endmodule
